// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one synchronous sprite ROM read port, with tagged returns.
// Optional macro PRIO0_EN gives requester 0 absolute priority over the rotation.
module sprite_rom_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 4,
   parameter int ROM_LATENCY = 1,
   parameter int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                      vga_clk,
   input  logic                      Reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [DATA_W-1:0]         rom_q,
   output logic                      rd_valid,
   output logic [ID_W-1:0]           rd_id,
   output logic [DATA_W-1:0]         rd_data
);
   localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win;
   logic              found;
   logic              grant;
   logic [ID_W:0]     cand;
   logic [ID_W-1:0]   ptr_next;
   logic              ptr_adv;
   logic [ADDR_W-1:0] addr_arr [NUM_REQ];
   logic [ADDR_W-1:0] addr_hold;
   logic              tag_vld_p [ROM_LATENCY];
   logic [ID_W-1:0]   tag_id_p  [ROM_LATENCY];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
   end

`ifdef PRIO0_EN
   // Requester 0 preempts; the rotation covers 1..NUM_REQ-1, so a pointer of 0 behaves as 1.
   logic [ID_W:0] base;

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      base  = (rr_ptr == '0) ? (ID_W+1)'(1) : {1'b0, rr_ptr};
      if (req[0]) begin
         found = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ - 1; k++) begin
            cand = base + (ID_W+1)'(k);
            if (cand >= NREQ_W) cand = cand - (NREQ_W - (ID_W+1)'(1));
            if (!found && req[cand[ID_W-1:0]]) begin
               found = 1'b1;
               win   = cand[ID_W-1:0];
            end
         end
      end
   end

   assign ptr_next = (win == LAST_ID) ? ID_W'(1) : win + ID_W'(1);
   assign ptr_adv  = grant && (win != '0);
`else
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!found && req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            win   = cand[ID_W-1:0];
         end
      end
   end

   assign ptr_next = (win == LAST_ID) ? '0 : win + ID_W'(1);
   assign ptr_adv  = grant;
`endif

   // Reset suppresses the grant immediately so nothing is launched while it is held.
   assign grant = found && !Reset;

   always_comb begin
      gnt = '0;
      if (grant) gnt[win] = 1'b1;
   end

   assign rom_address = grant ? addr_arr[win] : addr_hold;

   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         rr_ptr    <= '0;
         addr_hold <= '0;
      end else begin
         addr_hold <= rom_address;
         if (ptr_adv) rr_ptr <= ptr_next;
      end
   end

   // Tag pipeline: stage 0 loads at the grant edge, tracking the ROM read latency.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < ROM_LATENCY; i++) begin
            tag_vld_p[i] <= 1'b0;
            tag_id_p[i]  <= '0;
         end
      end else begin
         tag_vld_p[0] <= grant;
         tag_id_p[0]  <= win;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            tag_vld_p[i] <= tag_vld_p[i-1];
            tag_id_p[i]  <= tag_id_p[i-1];
         end
      end
   end

   // Output stage: capture rom_q alongside the final tag.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         rd_valid <= 1'b0;
         rd_id    <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= tag_vld_p[ROM_LATENCY-1];
         if (tag_vld_p[ROM_LATENCY-1]) begin
            rd_id   <= tag_id_p[ROM_LATENCY-1];
            rd_data <= rom_q;
         end
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM latency 1 and 3) share one request stream
// and are compared against a cycle-indexed grant history model.
module tb_sprite_rom_arbiter;
   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 4;

   logic            vga_clk = 1'b0;
   logic            Reset   = 1'b1;
   logic [N-1:0]    req     = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N-1:0]    gnt1, gnt3;
   logic [AW-1:0]   ra1, ra3;
   logic [DW-1:0]   q1, q3;
   logic            v1, v3;
   logic [1:0]      id1, id3;
   logic [DW-1:0]   d1, d3;
   logic [AW-1:0]   ap1;
   logic [AW-1:0]   ap3 [3];

   always #5 vga_clk = ~vga_clk;

   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(1)) dut_l1 (
      .vga_clk(vga_clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt1),
      .rom_address(ra1), .rom_q(q1), .rd_valid(v1), .rd_id(id1), .rd_data(d1));

   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(3)) dut_l3 (
      .vga_clk(vga_clk), .Reset(Reset), .req(req), .req_addr(req_addr), .gnt(gnt3),
      .rom_address(ra3), .rom_q(q3), .rd_valid(v3), .rd_id(id3), .rd_data(d3));

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return DW'(32'(a[3:0]) + 3 * 32'(a[7:4]) + 32'(a[9:8]));
   endfunction

   // Synchronous ROM models: address registered at the edge, word usable LATENCY edges later.
   always @(posedge vga_clk) begin
      ap1    <= ra1;
      ap3[0] <= ra3;
      ap3[1] <= ap3[0];
      ap3[2] <= ap3[1];
   end
   assign q1 = rom_word(ap1);
   assign q3 = rom_word(ap3[2]);

   int            n_pass = 0, n_fail = 0, n_total = 0;
   int            cyc = 0;
   int            ptr = 0;
   logic [AW-1:0] hold_addr = '0;
   logic [AW-1:0] addr [N];
   bit            hv  [4096];
   int            hid [4096];
   logic [AW-1:0] ha  [4096];
   logic [1:0]    held_id   [2];
   logic [DW-1:0] held_data [2];
   int            gcount [N];
   int            rd_cnt [2];
   logic [N-1:0]  pending = '0;
   logic [N-1:0]  last_gnt;
   logic [AW-1:0] last_ra;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int arb(input logic [N-1:0] r, input int p);
`ifdef PRIO0_EN
      if (r[0]) return 0;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (p + k) % N;
         if (c != 0 && r[c]) return c;
      end
`else
      for (int k = 0; k < N; k++) begin
         int c;
         c = (p + k) % N;
         if (r[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic check_rd(input int inst);
      int         L, c;
      bit         ev;
      logic       ov;
      logic [1:0] oid;
      logic [3:0] od;
      string      sfx;
      L   = (inst == 0) ? 1 : 3;
      sfx = (inst == 0) ? "_l1" : "_l3";
      c   = cyc - 1 - L;
      ev  = (c >= 0) && hv[c];
      if (ev) begin
         held_id[inst]   = 2'(hid[c]);
         held_data[inst] = rom_word(ha[c]);
      end
      ov  = (inst == 0) ? v1 : v3;
      oid = (inst == 0) ? id1 : id3;
      od  = (inst == 0) ? d1 : d3;
      if (ov === 1'b1) rd_cnt[inst]++;
      chk({"rd_valid", sfx}, 32'(ov), 32'(ev));
      chk({"rd_id", sfx}, 32'(oid), 32'(held_id[inst]));
      chk({"rd_data", sfx}, 32'(od), 32'(held_data[inst]));
   endtask

   task automatic cycle(input logic [N-1:0] r);
      int           w;
      logic [N-1:0] eg;
      req      = r;
      req_addr = {addr[3], addr[2], addr[1], addr[0]};
      #1;
      w  = arb(r, ptr);
      eg = (w >= 0) ? (N'(1) << w) : '0;
      if (w >= 0) hold_addr = addr[w];
      last_gnt = gnt1;
      last_ra  = ra1;
      chk("gnt_l1", 32'(gnt1), 32'(eg));
      chk("gnt_l3", 32'(gnt3), 32'(eg));
      chk("rom_address_l1", 32'(ra1), 32'(hold_addr));
      chk("rom_address_l3", 32'(ra3), 32'(hold_addr));
      hv[cyc]  = (w >= 0);
      hid[cyc] = w;
      ha[cyc]  = hold_addr;
      pending  = r & ~eg;
      if (w >= 0) begin
         gcount[w]++;
`ifdef PRIO0_EN
         if (w > 0) ptr = (w == N - 1) ? 1 : w + 1;
`else
         ptr = (w + 1) % N;
`endif
      end
      @(posedge vga_clk);
      cyc++;
      #1;
      check_rd(0);
      check_rd(1);
      @(negedge vga_clk);
   endtask

   task automatic check_reset_state();
      chk("rst_gnt_l1", 32'(gnt1), 32'(0));
      chk("rst_gnt_l3", 32'(gnt3), 32'(0));
      chk("rst_rd_valid_l1", 32'(v1), 32'(0));
      chk("rst_rd_valid_l3", 32'(v3), 32'(0));
      chk("rst_rd_id_l1", 32'(id1), 32'(0));
      chk("rst_rd_data_l3", 32'(d3), 32'(0));
      chk("rst_rom_address_l1", 32'(ra1), 32'(0));
   endtask

   // Starts and ends at a falling edge; reset is held across one rising edge.
   task automatic pulse_reset();
      #2;
      Reset = 1'b1;
      #1;
      check_reset_state();
      ptr       = 0;
      hold_addr = '0;
      pending   = '0;
      for (int c = cyc - 4; c <= cyc; c++) if (c >= 0) hv[c] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         held_id[i]   = '0;
         held_data[i] = '0;
      end
      @(posedge vga_clk);
      cyc++;
      #1;
      check_rd(0);
      check_rd(1);
      @(negedge vga_clk);
      Reset = 1'b0;
   endtask

   logic [N-1:0]  exp_seq [5];
   logic [AW-1:0] exp_ra  [5];

   initial begin
      for (int i = 0; i < N; i++) begin
         addr[i]   = AW'(16 * (i + 1));
         gcount[i] = 0;
      end
      for (int i = 0; i < 2; i++) begin
         held_id[i]   = '0;
         held_data[i] = '0;
         rd_cnt[i]    = 0;
      end
      #12;
      check_reset_state();
      @(negedge vga_clk);
      Reset = 1'b0;
      cyc   = 4;

      // Reset mid-stream, then the full rotation starting from requester 0.
      repeat (3) cycle(4'b1111);
      pulse_reset();
`ifdef PRIO0_EN
      for (int k = 0; k < 5; k++) begin
         exp_seq[k] = 4'b0001;
         exp_ra[k]  = 10'h010;
      end
`else
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_ra  = '{10'h010, 10'h020, 10'h030, 10'h040, 10'h010};
`endif
      for (int k = 0; k < 5; k++) begin
         cycle(4'b1111);
         chk("rotation_gnt", 32'(last_gnt), 32'(exp_seq[k]));
         chk("rotation_addr", 32'(last_ra), 32'(exp_ra[k]));
      end

      for (int i = 0; i < N; i++) gcount[i] = 0;
      repeat (8) cycle(4'b1111);
`ifdef PRIO0_EN
      chk("prio_count0", 32'(gcount[0]), 32'(8));
      chk("prio_count3", 32'(gcount[3]), 32'(0));
`else
      for (int i = 0; i < N; i++) chk("fair_count", 32'(gcount[i]), 32'(2));
`endif
      repeat (4) cycle(4'b0000);

      // Single requester held: granted every cycle at the top address.
      addr[2] = 10'h3FF;
      for (int i = 0; i < 2; i++) rd_cnt[i] = 0;
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0100);
         chk("sparse_gnt", 32'(last_gnt), 32'(4'b0100));
         chk("sparse_addr", 32'(last_ra), 32'(10'h3FF));
      end
      repeat (5) cycle(4'b0000);
      chk("sparse_returns_l1", 32'(rd_cnt[0]), 32'(5));
      chk("sparse_returns_l3", 32'(rd_cnt[1]), 32'(5));

      // Withdrawn request from requester 1 leaves no trace.
      pulse_reset();
      for (int i = 0; i < N; i++) gcount[i] = 0;
      cycle(4'b0011);
      chk("withdraw_first", 32'(last_gnt), 32'(4'b0001));
      repeat (3) cycle(4'b0001);
      repeat (4) cycle(4'b0000);
      chk("withdraw_count1", 32'(gcount[1]), 32'(0));

`ifdef PRIO0_EN
      // Requester 0 starves the rest; without it the others rotate from 1.
      for (int k = 0; k < 4; k++) begin
         cycle(4'b1111);
         chk("prio_hold", 32'(last_gnt), 32'(4'b0001));
      end
      exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100};
      for (int k = 0; k < 4; k++) begin
         cycle(4'b1110);
         chk("prio_rotate", 32'(last_gnt), 32'(exp_seq[k]));
      end
      repeat (4) cycle(4'b0000);
`endif

      // Random traffic with occasional resets; addresses held while a request is pending.
      for (int n = 0; n < 400; n++) begin
         logic [N-1:0] r;
         if ($urandom_range(0, 59) == 0) begin
            pulse_reset();
         end else begin
            r = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) if (!pending[i]) addr[i] = AW'($urandom);
            cycle(r);
         end
      end
      repeat (6) cycle(4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
